// File: rtl/ram_seq_ctrl_pkg.sv
// Shared types and helpers for the RAM sequencing front-end.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ram_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RDWAIT,
        ST_LATCH
    } seq_state_t;

    // Terminal value of the tick divider: counts 0..term then wraps.
    function automatic int div_term(input int clk_hz, input int tick_hz);
        return (clk_hz / tick_hz) - 1;
    endfunction

    // Counter width able to hold div_term; never narrower than one bit.
    function automatic int div_width(input int clk_hz, input int tick_hz);
        int term;
        term = div_term(clk_hz, tick_hz);
        return (term > 0) ? $clog2(term + 1) : 1;
    endfunction

endpackage

// File: rtl/ram_seq_ctrl_key_debounce.sv
// Pushbutton debouncer with a shared 2-flop synchronizer for auxiliary switches.
// Latency: 2 cycles sync, then DEB_CYCLES stable cycles before press fires.
// Backpressure: none; press is a one-cycle pulse the consumer may ignore.
//
// Ports:
//   clk, rst_n   clock and async active-low reset
//   key_n        raw active-low pushbutton
//   aux / aux_s  raw / synchronized switch levels (sync stage only)
//   press        one-cycle pulse on an accepted 1->0 debounced transition
module ram_seq_ctrl_key_debounce #(
    parameter int DEB_CYCLES = 1000000,
    parameter int AUX_W      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_n,
    input  logic [AUX_W-1:0] aux,
    output logic [AUX_W-1:0] aux_s,
    output logic             press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [AUX_W:0]   sync1;
    logic [AUX_W:0]   sync2;
    logic             key_s;
    logic             key_db;
    logic [CNT_W-1:0] cnt;

    assign key_s = sync2[0];
    assign aux_s = sync2[AUX_W:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {aux, key_n};
            sync2 <= sync1;
        end
    end

    // cnt counts consecutive cycles the synchronized key disagrees with the
    // accepted level; any agreeing cycle restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else if (key_s == key_db) begin
            cnt    <= '0;
            press  <= 1'b0;
        end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
            key_db <= key_s;
            cnt    <= '0;
            press  <= ~key_s;
        end else begin
            cnt    <= cnt + CNT_W'(1);
            press  <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_seq_ctrl.sv
// Sequencer for the single-port lab RAM: tick/step advance, write strobe, read-back latch.
// Latency: event edge to disp update is RD_LAT+2 cycles with write, RD_LAT+1 without.
// Backpressure: advance events arriving while busy are dropped, never queued.
//
// Ports:
//   CLOCK_50, KEY0            clock, async active-low reset
//   step_n, auto_mode, wr_en  raw user inputs (synchronized internally)
//   wr_data                   switch data, sampled at the advance event
//   ram_q / ram_addr / ram_wdata / ram_we   RAM interface
//   disp_addr, disp_data      last completed access for the HEX decoders
//   busy, tick                access in progress, divider pulse
module ram_seq_ctrl
    import ram_seq_ctrl_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic              CLOCK_50,
    input  logic              KEY0,
    input  logic              step_n,
    input  logic              auto_mode,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              busy,
    output logic              tick
);

    localparam int DIV_TERM = div_term(CLK_HZ, TICK_HZ);
    localparam int DIV_W    = div_width(CLK_HZ, TICK_HZ);
    localparam int WAIT_W   = $clog2(RD_LAT + 1);

    logic [1:0]        aux_s;
    logic              auto_s;
    logic              wr_en_s;
    logic              step_press;
    logic [DIV_W-1:0]  div_cnt;
    logic              adv;
    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              cap_wdata;
    logic              do_latch;

    ram_seq_ctrl_key_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .AUX_W      (2)
    ) u_key (
        .clk   (CLOCK_50),
        .rst_n (KEY0),
        .key_n (step_n),
        .aux   ({wr_en, auto_mode}),
        .aux_s (aux_s),
        .press (step_press)
    );

    assign wr_en_s = aux_s[1];
    assign auto_s  = aux_s[0];

    // Free-running divider; runs regardless of mode.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_W'(DIV_TERM)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_W'(DIV_TERM));

    // Only the source chosen by the mode switch can start an access.
    assign adv = auto_s ? tick : step_press;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // ram_we decodes straight from the state register so an async reset
    // kills the strobe immediately, even mid-access.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        ram_we    = 1'b0;
        busy      = 1'b1;
        cap_wdata = 1'b0;
        do_latch  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (adv) begin
                    cap_wdata = 1'b1;
                    if (wr_en_s) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_RDWAIT;
                        wait_nxt  = WAIT_W'(RD_LAT);
                    end
                end
            end
            ST_WRITE: begin
                ram_we    = 1'b1;
                state_nxt = ST_RDWAIT;
                wait_nxt  = WAIT_W'(RD_LAT);
            end
            ST_RDWAIT: begin
                if (wait_cnt == WAIT_W'(1)) begin
                    state_nxt = ST_LATCH;
                end else begin
                    wait_nxt = wait_cnt - WAIT_W'(1);
                end
            end
            ST_LATCH: begin
                do_latch  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ram_addr only moves on the LATCH edge, so it is stable for the whole access.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            disp_addr <= '0;
            disp_data <= '0;
        end else begin
            if (cap_wdata) begin
                ram_wdata <= wr_data;
            end
            if (do_latch) begin
                disp_addr <= ram_addr;
                disp_data <= ram_q;
                ram_addr  <= ram_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl with a behavioural 32x8 RAM (read latency 1).
// Cycle numbers below count rising edges since the last reset release.
module tb_ram_seq_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       KEY0;
    logic       step_n;
    logic       auto_mode;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] ram_q;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic [4:0] disp_addr;
    logic [7:0] disp_data;
    logic       busy;
    logic       tick;

    logic [7:0] mem [0:31];
    logic       fill_req = 1'b0;
    int         cyc = 0;
    int         we_cnt = 0;
    int         tests = 0;
    int         fails = 0;

    ram_seq_ctrl #(
        .CLK_HZ     (20),
        .TICK_HZ    (1),
        .ADDR_W     (5),
        .DATA_W     (8),
        .RD_LAT     (1),
        .DEB_CYCLES (4)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .KEY0      (KEY0),
        .step_n    (step_n),
        .auto_mode (auto_mode),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .ram_q     (ram_q),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .busy      (busy),
        .tick      (tick)
    );

    initial forever #5 CLOCK_50 = ~CLOCK_50;

    // RAM model: synchronous write, registered read (latency 1).
    always @(posedge CLOCK_50) begin
        if (fill_req) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_q <= mem[ram_addr];
    end

    always @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge CLOCK_50) begin
        if (ram_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge CLOCK_50);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " ram_we"},    32'(ram_we),    0);
        check({tag, " busy"},      32'(busy),      0);
        check({tag, " tick"},      32'(tick),      0);
        check({tag, " ram_addr"},  32'(ram_addr),  0);
        check({tag, " ram_wdata"}, 32'(ram_wdata), 0);
        check({tag, " disp_addr"}, 32'(disp_addr), 0);
        check({tag, " disp_data"}, 32'(disp_data), 0);
    endtask

    initial begin
        KEY0      = 1'b0;
        step_n    = 1'b1;
        auto_mode = 1'b1;
        wr_en     = 1'b1;
        wr_data   = 8'hA5;
        repeat (3) @(negedge CLOCK_50);
        check_zero("reset");
        KEY0 = 1'b1;

        // Divider: tick only in cycle 19 of each 20.
        wait_cyc(18); check("tick c18", 32'(tick), 0);
        wait_cyc(19); check("tick c19", 32'(tick), 1);
        check("idle busy c19", 32'(busy), 0);

        // Auto mode with write: three accesses, read-after-write of 0xA5.
        for (int k = 0; k < 3; k++) begin
            wait_cyc(20 + 20 * k);
            check($sformatf("we pulse %0d", k), 32'(ram_we), 1);
            check($sformatf("wr addr %0d", k), 32'(ram_addr), 32'(k));
            check($sformatf("wdata %0d", k), 32'(ram_wdata), 32'hA5);
            wait_cyc(21 + 20 * k);
            check($sformatf("we single %0d", k), 32'(ram_we), 0);
            wait_cyc(22 + 20 * k);
            check($sformatf("disp early %0d", k), 32'(busy), 1);
            wait_cyc(23 + 20 * k);
            check($sformatf("disp addr %0d", k), 32'(disp_addr), 32'(k));
            check($sformatf("disp data %0d", k), 32'(disp_data), 32'hA5);
            check($sformatf("busy done %0d", k), 32'(busy), 0);
        end

        // Preload 0x00..0x1F and switch to read-only scanning.
        wait_cyc(64);
        check("we count auto", 32'(we_cnt), 3);
        wr_en    = 1'b0;
        fill_req = 1'b1;
        wait_cyc(65);
        fill_req = 1'b0;

        for (int k = 0; k < 30; k++) begin
            wait_cyc(80 + 20 * k);
            check($sformatf("scan busy %0d", k), 32'(busy), 1);
            check($sformatf("scan addr %0d", k), 32'(ram_addr), 32'((3 + k) % 32));
            wait_cyc(82 + 20 * k);
            check($sformatf("scan disp_addr %0d", k), 32'(disp_addr), 32'((3 + k) % 32));
            check($sformatf("scan disp_data %0d", k), 32'(disp_data), 32'((3 + k) % 32));
        end
        wait_cyc(665);
        check("we count scan", 32'(we_cnt), 3);
        check("wrap addr", 32'(ram_addr), 1);

        // Manual mode: two 3-cycle bounces are rejected.
        auto_mode = 1'b0;
        wait_cyc(670); step_n = 1'b0;
        wait_cyc(673); step_n = 1'b1;
        wait_cyc(676); step_n = 1'b0;
        wait_cyc(679); step_n = 1'b1;
        wait_cyc(690);
        check("bounce addr", 32'(ram_addr), 1);
        check("bounce busy", 32'(busy), 0);

        // Stable 10-cycle press: exactly one access.
        wait_cyc(692); step_n = 1'b0;
        wait_cyc(699); check("press busy", 32'(busy), 1);
        wait_cyc(701);
        check("press disp_addr", 32'(disp_addr), 1);
        check("press disp_data", 32'(disp_data), 1);
        check("press addr", 32'(ram_addr), 2);
        wait_cyc(702); step_n = 1'b1;
        wait_cyc(730); check("tick ignored addr", 32'(ram_addr), 2);

        // Press held 20 cycles: still one access.
        wait_cyc(732); step_n = 1'b0;
        wait_cyc(739); check("hold busy", 32'(busy), 1);
        wait_cyc(752); step_n = 1'b1;
        wait_cyc(760);
        check("hold addr", 32'(ram_addr), 3);
        check("hold disp_addr", 32'(disp_addr), 2);

        // Press-started access; mode flips to auto mid-access and a tick
        // lands while busy: it must be dropped.
        wait_cyc(771); step_n = 1'b0;
        wait_cyc(776); auto_mode = 1'b1;
        wait_cyc(778);
        check("overlap busy", 32'(busy), 1);
        check("overlap addr", 32'(ram_addr), 3);
        wait_cyc(779);
        check("overlap tick", 32'(tick), 1);
        check("overlap busy2", 32'(busy), 1);
        wait_cyc(780);
        check("overlap idle", 32'(busy), 0);
        check("overlap addr2", 32'(ram_addr), 4);
        check("overlap disp", 32'(disp_addr), 3);
        wait_cyc(785); step_n = 1'b1;
        wait_cyc(790); check("no double", 32'(ram_addr), 4);
        wait_cyc(799); check("idle before tick", 32'(busy), 0);
        wait_cyc(802);
        check("auto resume addr", 32'(disp_addr), 4);
        check("auto resume data", 32'(disp_data), 4);
        check("auto resume next", 32'(ram_addr), 5);

        // Reset in the middle of a write.
        wait_cyc(805);
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        wait_cyc(820);
        check("pre-reset we", 32'(ram_we), 1);
        check("pre-reset addr", 32'(ram_addr), 5);
        #2 KEY0 = 1'b0;
        #1 check_zero("mid reset");
        @(negedge CLOCK_50);
        KEY0 = 1'b1;
        wait_cyc(20);
        check("post-reset we", 32'(ram_we), 1);
        check("post-reset addr", 32'(ram_addr), 0);
        check("post-reset wdata", 32'(ram_wdata), 32'h3C);
        wait_cyc(23);
        check("post-reset disp_addr", 32'(disp_addr), 0);
        check("post-reset disp_data", 32'(disp_data), 32'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_seq_ctrl.md
Name: ram_seq_ctrl

Overview:
- Sequencing front-end for the 32x8 single-port lab RAM; replaces the free-running 1 Hz address counter.
- Generates a clean one-cycle tick from CLOCK_50 and advances the RAM address either automatically on each tick or manually on a debounced pushbutton.
- Issues a one-cycle write strobe with switch data, waits the RAM read latency and latches the read-back word and its address for the HEX display decoders.
- The RAM runs on CLOCK_50, so the whole path is single-clock.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1, advance-tick rate in auto mode.
- ADDR_W, 5, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles (≥1).
- DEB_CYCLES, 1000000, cycles step_n must be stable before it is accepted (20 ms).

Ports:
- CLOCK_50  in  1  system clock.
- KEY0  in  1  asynchronous active-low reset.
- step_n  in  1  raw pushbutton, active-low, asynchronous to the clock.
- auto_mode  in  1  switch; 1 = advance on tick, 0 = advance on step press.
- wr_en  in  1  switch; 1 = write wr_data before each read.
- wr_data  in  DATA_W  switch data to write.
- ram_q  in  DATA_W  RAM read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable, one-cycle pulse.
- disp_addr  out  ADDR_W  address of the last completed access.
- disp_data  out  DATA_W  data read at disp_addr.
- busy  out  1  high while an access is in progress.
- tick  out  1  one-cycle pulse at TICK_HZ.

Behaviour:
- Reset (KEY0=0, async):
  - All outputs are 0, the FSM is in IDLE, and the divider, debounce and synchronizer flops are cleared.
  - ram_we drops immediately, even mid-access.
  - After release, the first access targets address 0.
- Inputs: step_n, auto_mode and wr_en each pass through a 2-flop synchronizer; wr_data is sampled only at the advance event.
- Divider:
  - Counts 0..CLK_HZ/TICK_HZ-1 and wraps.
  - tick=1 for exactly the cycle in which the count is at terminal value.
  - It runs in both modes.
- Debounce:
  - The synchronized step_n must hold a new level for DEB_CYCLES consecutive cycles before the debounced level changes.
  - A debounced 1->0 transition produces a one-cycle step_press.
  - Holding the button gives one press only.
- Advance event = auto_mode_s ? tick : step_press, evaluated only in IDLE. Events in any other state are dropped, not queued.
- FSM states: IDLE, WRITE, RDWAIT, LATCH.
  - IDLE:
    - On an advance event, capture ram_wdata<=wr_data.
    - If wr_en_s, go to WRITE; otherwise go to RDWAIT with the wait counter set to RD_LAT.
  - WRITE: ram_we=1 for this single cycle, then go to RDWAIT.
  - RDWAIT: hold for RD_LAT cycles, then go to LATCH.
  - LATCH:
    - disp_addr<=ram_addr, disp_data<=ram_q.
    - ram_addr<=ram_addr+1, wrapping 2^ADDR_W-1 -> 0.
    - Return to IDLE.
- Timing:
  - ram_addr is constant from the event until the LATCH edge.
  - busy=1 in every state except IDLE.
  - Event edge to disp update: RD_LAT+2 cycles with write, RD_LAT+1 without.
- Read-after-write: disp_data equals the word just written.
- A mode or wr_en change mid-access has no effect until the next IDLE event.
- Simultaneous tick and step_press: only the one selected by auto_mode counts.

Decomposition:
- Shared package: FSM state enum (IDLE/WRITE/RDWAIT/LATCH); function computing the divider terminal count CLK_HZ/TICK_HZ-1 and its counter width.
- Sub-module: key_debounce (2-flop sync, stability counter, falling-edge pulse output). The synchronizers for auto_mode and wr_en reuse its sync stage only.

Test Plan:
- Sim parameters: CLK_HZ=20, TICK_HZ=1, DEB_CYCLES=4, RD_LAT=1.
- Reset then auto_mode=1, wr_en=1, wr_data=0xA5, RAM model -> ram_we pulses once per 20 cycles at ram_addr 0,1,2; disp_data=0xA5 and disp_addr=0,1,2 exactly 3 cycles after each tick.
- wr_en=0 after filling 0..31 with 0x00..0x1F -> read-only scan; ram_we never asserts; disp_data==disp_addr; address wraps 31->0 and the next access reads 0x00.
- auto_mode=0, step_n bounces 3 cycles low/high then holds low 10 cycles -> exactly one access; a bounce shorter than 4 cycles produces none; the tick has no effect.
- Step press held through 2 accesses' worth of time, and a tick arriving while busy=1 -> the extra event is dropped, no double increment, busy returns to 0 before the next event.
- KEY0 asserted during WRITE -> ram_we=0 in the same cycle, all outputs 0; after release the next access uses address 0.
